// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/timing generator with active window, prefetch window and frame counter.
// Optional vertical-blank interrupt logic is built when VGA_VBLANK_IRQ_EN is defined.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PREFETCH = 1,
    parameter int unsigned H_W      = 10,
    parameter int unsigned V_W      = 10,
    parameter int unsigned FRAME_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ce_i,
    input  logic               en_i,
`ifdef VGA_VBLANK_IRQ_EN
    input  logic               irq_ack_i,
    output logic               irq_o,
    output logic               irq_ovf_o,
`endif
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               active_o,
    output logic [H_W-1:0]     x_o,
    output logic [V_W-1:0]     y_o,
    output logic               fetch_o,
    output logic [H_W-1:0]     fetch_x_o,
    output logic [V_W-1:0]     fetch_y_o,
    output logic               line_start_o,
    output logic               frame_start_o,
    output logic [H_W-1:0]     hc_o,
    output logic [V_W-1:0]     vc_o,
    output logic [FRAME_W-1:0] frame_cnt_o
);

    localparam int unsigned H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int unsigned H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int unsigned V_BLANK = V_FP + V_SYNC + V_BP;
    localparam int unsigned V_TOTAL = V_BLANK + V_ACTIVE;

    if (64'(H_TOTAL) - 64'd1 >= (64'd1 << H_W)) begin : g_h_w_err
        $error("vga_timing_gen: H_TOTAL-1 does not fit in H_W bits");
    end
    if (64'(V_TOTAL) - 64'd1 >= (64'd1 << V_W)) begin : g_v_w_err
        $error("vga_timing_gen: V_TOTAL-1 does not fit in V_W bits");
    end
    if (PREFETCH > H_BLANK) begin : g_prefetch_err
        $error("vga_timing_gen: PREFETCH exceeds horizontal blanking");
    end

    logic [H_W-1:0]     hc_q, hc_d;
    logic [V_W-1:0]     vc_q, vc_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [31:0]        hc_w, vc_w;
    logic               h_end, v_end;

    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               active_q, active_d;
    logic [H_W-1:0]     x_q, x_d;
    logic [V_W-1:0]     y_q, y_d;
    logic               fetch_q, fetch_d;
    logic [H_W-1:0]     fetch_x_q, fetch_x_d;
    logic [V_W-1:0]     fetch_y_q, fetch_y_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;

    assign hc_w = 32'(hc_q);
    assign vc_w = 32'(vc_q);

    // Decodes are taken from the pre-update counters so all outputs share one cycle of lag.
    always_comb begin
        h_end         = (hc_w == H_TOTAL - 1);
        v_end         = (vc_w == V_TOTAL - 1);
        hc_d          = h_end ? '0 : hc_q + H_W'(1);
        vc_d          = vc_q;
        frame_d       = frame_q;
        if (h_end) begin
            vc_d = v_end ? '0 : vc_q + V_W'(1);
            if (v_end) begin
                frame_d = frame_q + FRAME_W'(1);
            end
        end

        hsync_d       = (hc_w >= H_FP && hc_w < H_FP + H_SYNC) ? HS_POL : !HS_POL;
        vsync_d       = (vc_w >= V_FP && vc_w < V_FP + V_SYNC) ? VS_POL : !VS_POL;

        active_d      = (hc_w >= H_BLANK) && (vc_w >= V_BLANK);
        x_d           = '0;
        y_d           = '0;
        if (active_d) begin
            x_d = H_W'(hc_w - H_BLANK);
            y_d = V_W'(vc_w - V_BLANK);
        end

        fetch_d       = (vc_w >= V_BLANK) && (hc_w >= H_BLANK - PREFETCH)
                        && (hc_w < H_TOTAL - PREFETCH);
        fetch_x_d     = '0;
        fetch_y_d     = '0;
        if (fetch_d) begin
            fetch_x_d = H_W'(hc_w - (H_BLANK - PREFETCH));
            fetch_y_d = V_W'(vc_w - V_BLANK);
        end

        line_start_d  = (hc_w == 0);
        frame_start_d = (hc_w == 0) && (vc_w == 0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hc_q          <= '0;
            vc_q          <= '0;
            frame_q       <= '0;
            hsync_q       <= !HS_POL;
            vsync_q       <= !VS_POL;
            active_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            fetch_q       <= 1'b0;
            fetch_x_q     <= '0;
            fetch_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (!en_i) begin
            hc_q          <= '0;
            vc_q          <= '0;
            frame_q       <= '0;
            hsync_q       <= !HS_POL;
            vsync_q       <= !VS_POL;
            active_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            fetch_q       <= 1'b0;
            fetch_x_q     <= '0;
            fetch_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (ce_i) begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            frame_q       <= frame_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            fetch_q       <= fetch_d;
            fetch_x_q     <= fetch_x_d;
            fetch_y_q     <= fetch_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end else begin
            // Strobes never stretch across ce gaps.
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

`ifdef VGA_VBLANK_IRQ_EN
    logic irq_q, irq_ovf_q, irq_set;

    assign irq_set = ce_i && frame_start_d;

    // Set has priority over ack; overflow marks a frame start while the previous irq was pending.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q     <= 1'b0;
            irq_ovf_q <= 1'b0;
        end else if (!en_i) begin
            irq_q     <= 1'b0;
            irq_ovf_q <= 1'b0;
        end else begin
            if (irq_set) begin
                irq_q <= 1'b1;
            end else if (irq_ack_i) begin
                irq_q <= 1'b0;
            end
            if (irq_set && irq_q) begin
                irq_ovf_q <= 1'b1;
            end else if (irq_ack_i) begin
                irq_ovf_q <= 1'b0;
            end
        end
    end

    assign irq_o     = irq_q;
    assign irq_ovf_o = irq_ovf_q;
`endif

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign active_o      = active_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign fetch_o       = fetch_q;
    assign fetch_x_o     = fetch_x_q;
    assign fetch_y_o     = fetch_y_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
    assign hc_o          = hc_q;
    assign vc_o          = vc_q;
    assign frame_cnt_o   = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default 640x480 timing, a tiny 12x7 timing
// driven from a vector table, PREFETCH=0 equivalence, ce gating, en/rst behaviour and irq.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Default-parameter instance
    logic        def_ce = 1'b0, def_en = 1'b0, def_ack = 1'b0;
    logic        def_irq, def_ovf;
    logic        def_hs, def_vs, def_act, def_fe, def_ls, def_fs;
    logic [9:0]  def_x, def_fx, def_hc;
    logic [9:0]  def_y, def_fy, def_vc;
    logic [15:0] def_fc;

    vga_timing_gen u_def (
        .clk_i(clk), .rst_i(rst), .ce_i(def_ce), .en_i(def_en),
`ifdef VGA_VBLANK_IRQ_EN
        .irq_ack_i(def_ack), .irq_o(def_irq), .irq_ovf_o(def_ovf),
`endif
        .hsync_o(def_hs), .vsync_o(def_vs), .active_o(def_act), .x_o(def_x), .y_o(def_y),
        .fetch_o(def_fe), .fetch_x_o(def_fx), .fetch_y_o(def_fy),
        .line_start_o(def_ls), .frame_start_o(def_fs),
        .hc_o(def_hc), .vc_o(def_vc), .frame_cnt_o(def_fc)
    );

    // Small timing: H 8/1/2/1 (total 12), V 4/1/1/1 (total 7), PREFETCH=1
    logic       sm_ce = 1'b0, sm_en = 1'b0, sm_ack = 1'b0;
    logic       sm_irq, sm_ovf;
    logic       sm_hs, sm_vs, sm_act, sm_fe, sm_ls, sm_fs;
    logic [3:0] sm_x, sm_fx, sm_hc, sm_fc;
    logic [2:0] sm_y, sm_fy, sm_vc;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PREFETCH(1), .H_W(4), .V_W(3), .FRAME_W(4)
    ) u_sm (
        .clk_i(clk), .rst_i(rst), .ce_i(sm_ce), .en_i(sm_en),
`ifdef VGA_VBLANK_IRQ_EN
        .irq_ack_i(sm_ack), .irq_o(sm_irq), .irq_ovf_o(sm_ovf),
`endif
        .hsync_o(sm_hs), .vsync_o(sm_vs), .active_o(sm_act), .x_o(sm_x), .y_o(sm_y),
        .fetch_o(sm_fe), .fetch_x_o(sm_fx), .fetch_y_o(sm_fy),
        .line_start_o(sm_ls), .frame_start_o(sm_fs),
        .hc_o(sm_hc), .vc_o(sm_vc), .frame_cnt_o(sm_fc)
    );

    // Same small timing with PREFETCH=0, free running
    logic       p0_ce = 1'b1, p0_en = 1'b1, p0_ack = 1'b0;
    logic       p0_irq, p0_ovf;
    logic       p0_hs, p0_vs, p0_act, p0_fe, p0_ls, p0_fs;
    logic [3:0] p0_x, p0_fx, p0_hc, p0_fc;
    logic [2:0] p0_y, p0_fy, p0_vc;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .PREFETCH(0), .H_W(4), .V_W(3), .FRAME_W(4)
    ) u_p0 (
        .clk_i(clk), .rst_i(rst), .ce_i(p0_ce), .en_i(p0_en),
`ifdef VGA_VBLANK_IRQ_EN
        .irq_ack_i(p0_ack), .irq_o(p0_irq), .irq_ovf_o(p0_ovf),
`endif
        .hsync_o(p0_hs), .vsync_o(p0_vs), .active_o(p0_act), .x_o(p0_x), .y_o(p0_y),
        .fetch_o(p0_fe), .fetch_x_o(p0_fx), .fetch_y_o(p0_fy),
        .line_start_o(p0_ls), .frame_start_o(p0_fs),
        .hc_o(p0_hc), .vc_o(p0_vc), .frame_cnt_o(p0_fc)
    );

    int p0_bad = 0;
    int p0_act_seen = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (p0_act) p0_act_seen++;
            if (p0_fe !== p0_act || p0_fx !== p0_x || p0_fy !== p0_y) p0_bad++;
        end
    end

    task automatic check(input string name, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int n;  int ce; int en;
        int hc; int vc; int hs; int vs; int act; int x; int y;
        int fe; int fx; int fy; int ls; int fs; int fc;
    } vec_t;

    vec_t vecs[22];

    initial begin
        int first_hfall, hrise, second_hfall, vfall, vrise;
        int act_rise, act_x, act_y, fe_rise, fe_fx, fe_fy, fe_act;
        int ls_cnt, ls_first, ls_second, hold_bad;
        logic prev_hs, prev_vs, prev_act, prev_fe;

        //      n  ce en  hc vc hs vs act x  y fe fx fy ls fs fc
        vecs[0]  = '{1,  1, 1,  1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        vecs[1]  = '{1,  1, 1,  2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1,  1, 1,  3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1,  1, 1,  4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{8,  1, 1,  0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{1,  1, 1,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        vecs[6]  = '{12, 1, 1,  1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        vecs[7]  = '{15, 1, 1,  4, 3, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[8]  = '{1,  1, 1,  5, 3, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
        vecs[9]  = '{7,  1, 1,  0, 4, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{1,  1, 1,  1, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        vecs[11] = '{34, 1, 1, 11, 6, 1, 1, 1, 6, 3, 1, 7, 3, 0, 0, 0};
        vecs[12] = '{1,  1, 1,  0, 0, 1, 1, 1, 7, 3, 0, 0, 0, 0, 0, 1};
        vecs[13] = '{1,  1, 1,  1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        vecs[14] = '{1,  0, 1,  1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[15] = '{3,  0, 1,  1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[16] = '{1,  1, 1,  2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[17] = '{1,  1, 0,  0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[18] = '{2,  0, 0,  0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[19] = '{1,  1, 1,  1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        vecs[20] = '{40, 1, 1,  5, 3, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
        vecs[21] = '{1,  1, 0,  0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        // Reset values while rst is held
        tick();
        tick();
        check("rst_def_hc", 32'(def_hc), 0);
        check("rst_def_hs", 32'(def_hs), 1);
        check("rst_def_vs", 32'(def_vs), 1);
        check("rst_sm_act", 32'(sm_act), 0);
        check("rst_sm_fs", 32'(sm_fs), 0);
        check("rst_sm_fc", 32'(sm_fc), 0);

        // Default timing, continuous ce
        rst = 1'b0;
        def_en = 1'b1;
        def_ce = 1'b1;
        first_hfall = 0; hrise = 0; second_hfall = 0; vfall = 0; vrise = 0;
        act_rise = 0; act_x = -1; act_y = -1; fe_rise = 0; fe_fx = -1; fe_fy = -1; fe_act = -1;
        prev_hs = def_hs; prev_vs = def_vs; prev_act = def_act; prev_fe = def_fe;
        for (int c = 1; c <= 36801; c++) begin
            tick();
            if (prev_hs && !def_hs) begin
                if (first_hfall == 0) first_hfall = c;
                else if (second_hfall == 0) second_hfall = c;
            end
            if (!prev_hs && def_hs && hrise == 0) hrise = c;
            if (prev_vs && !def_vs && vfall == 0) vfall = c;
            if (!prev_vs && def_vs && vrise == 0) vrise = c;
            if (!prev_act && def_act && act_rise == 0) begin
                act_rise = c; act_x = 32'(def_x); act_y = 32'(def_y);
            end
            if (!prev_fe && def_fe && fe_rise == 0) begin
                fe_rise = c; fe_fx = 32'(def_fx); fe_fy = 32'(def_fy); fe_act = 32'(def_act);
            end
            if (c == 36799) begin
                check("def_last_fetch_x", 32'(def_fx), 639);
                check("def_pre_last_x", 32'(def_x), 638);
            end
            if (c == 36800) begin
                check("def_last_x", 32'(def_x), 639);
                check("def_last_act", 32'(def_act), 1);
                check("def_fetch_done", 32'(def_fe), 0);
            end
            if (c == 36801) begin
                check("def_hblank_act", 32'(def_act), 0);
                check("def_hblank_x", 32'(def_x), 0);
                check("def_hblank_y", 32'(def_y), 0);
            end
            prev_hs = def_hs; prev_vs = def_vs; prev_act = def_act; prev_fe = def_fe;
        end
        check("def_hsync_first_fall", first_hfall, 17);
        check("def_hsync_width", hrise - first_hfall, 96);
        check("def_line_period", second_hfall - first_hfall, 800);
        check("def_vsync_fall", vfall, 8001);
        check("def_vsync_width", vrise - vfall, 1600);
        check("def_active_rise", act_rise, 36161);
        check("def_active_x0", act_x, 0);
        check("def_active_y0", act_y, 0);
        check("def_fetch_rise", fe_rise, 36160);
        check("def_fetch_x0", fe_fx, 0);
        check("def_fetch_y0", fe_fy, 0);
        check("def_fetch_lead_act", fe_act, 0);

        // ce toggling 1,0,1,0 on default timing
        def_en = 1'b0;
        tick();
        check("def_en_off_hc", 32'(def_hc), 0);
        def_en = 1'b1;
        ls_cnt = 0; ls_first = 0; ls_second = 0; hold_bad = 0;
        for (int k = 1; k <= 3201; k++) begin
            def_ce = (k % 2 == 1);
            tick();
            if (def_ls) begin
                ls_cnt++;
                if (ls_first == 0) ls_first = k;
                else if (ls_second == 0) ls_second = k;
            end
            if (32'(def_hc) != ((k + 1) / 2) % 800) hold_bad++;
        end
        check("ce_ls_count", ls_cnt, 3);
        check("ce_ls_first", ls_first, 1);
        check("ce_line_period", ls_second - ls_first, 1600);
        check("ce_hold_mismatches", hold_bad, 0);
        def_ce = 1'b1;

        // Small timing vector table
        foreach (vecs[i]) begin
            sm_ce = vecs[i].ce[0];
            sm_en = vecs[i].en[0];
            for (int j = 0; j < vecs[i].n; j++) tick();
            check($sformatf("v%0d.hc", i), 32'(sm_hc), vecs[i].hc);
            check($sformatf("v%0d.vc", i), 32'(sm_vc), vecs[i].vc);
            check($sformatf("v%0d.hs", i), 32'(sm_hs), vecs[i].hs);
            check($sformatf("v%0d.vs", i), 32'(sm_vs), vecs[i].vs);
            check($sformatf("v%0d.act", i), 32'(sm_act), vecs[i].act);
            check($sformatf("v%0d.x", i), 32'(sm_x), vecs[i].x);
            check($sformatf("v%0d.y", i), 32'(sm_y), vecs[i].y);
            check($sformatf("v%0d.fe", i), 32'(sm_fe), vecs[i].fe);
            check($sformatf("v%0d.fx", i), 32'(sm_fx), vecs[i].fx);
            check($sformatf("v%0d.fy", i), 32'(sm_fy), vecs[i].fy);
            check($sformatf("v%0d.ls", i), 32'(sm_ls), vecs[i].ls);
            check($sformatf("v%0d.fs", i), 32'(sm_fs), vecs[i].fs);
            check($sformatf("v%0d.fc", i), 32'(sm_fc), vecs[i].fc);
        end

`ifdef VGA_VBLANK_IRQ_EN
        // Interrupt set, ack, set-wins, overflow and clear
        sm_en = 1'b0;
        tick();
        sm_en = 1'b1;
        sm_ce = 1'b1;
        sm_ack = 1'b0;
        tick();
        check("irq_set", 32'(sm_irq), 1);
        check("irq_ovf_idle", 32'(sm_ovf), 0);
        sm_ack = 1'b1;
        tick();
        check("irq_ack_clear", 32'(sm_irq), 0);
        sm_ack = 1'b0;
        for (int j = 0; j < 82; j++) tick();
        sm_ack = 1'b1;
        tick();
        check("irq_set_wins_fs", 32'(sm_fs), 1);
        check("irq_set_wins", 32'(sm_irq), 1);
        check("irq_no_ovf", 32'(sm_ovf), 0);
        sm_ack = 1'b0;
        for (int j = 0; j < 84; j++) tick();
        check("irq_ovf_fs", 32'(sm_fs), 1);
        check("irq_ovf_set", 32'(sm_ovf), 1);
        sm_ack = 1'b1;
        tick();
        check("irq_ack_irq", 32'(sm_irq), 0);
        check("irq_ack_ovf", 32'(sm_ovf), 0);
        sm_ack = 1'b0;
`endif

        // Asynchronous reset mid-frame
        sm_en = 1'b0;
        tick();
        sm_en = 1'b1;
        sm_ce = 1'b1;
        for (int j = 0; j < 45; j++) tick();
        check("pre_rst_act", 32'(sm_act), 1);
        check("pre_rst_x", 32'(sm_x), 4);
        check("pre_rst_hc", 32'(sm_hc), 9);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_hc", 32'(sm_hc), 0);
        check("async_rst_vc", 32'(sm_vc), 0);
        check("async_rst_act", 32'(sm_act), 0);
        check("async_rst_x", 32'(sm_x), 0);
        check("async_rst_fe", 32'(sm_fe), 0);
        check("async_rst_hs", 32'(sm_hs), 1);
        check("async_rst_vs", 32'(sm_vs), 1);
        tick();
        rst = 1'b0;

        check("p0_active_seen_nonzero", 32'(p0_act_seen > 0), 1);
        check("p0_fetch_eq_active", p0_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480@60Hz sync generator. Produces horizontal and vertical sync, active video, pixel coordinates, line and frame strobes, and a frame counter, all from one clock, with a pixel clock-enable and a run enable. It adds a configurable prefetch window so the framebuffer/text pipeline can fetch PREFETCH pixels ahead of display, with no hard-coded 1-pixel adjustment. It sits between the clock domain and the vga_top pixel pipeline.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
HS_POL, 0, hsync asserted level (0 = active low)
VS_POL, 0, vsync asserted level
PREFETCH, 1, fetch window lead in pixels; legal range 0..H_FP+H_SYNC+H_BP
H_W, 10, horizontal counter and coordinate width
V_W, 10, vertical counter and coordinate width
FRAME_W, 16, frame counter width

Ports:
clk_i  in  1  pixel-domain clock
rst_i  in  1  asynchronous reset, active high
ce_i  in  1  pixel clock enable; timing advances only when ce_i=1
en_i  in  1  run enable; 0 holds generator idle
hsync_o  out  1  registered hsync
vsync_o  out  1  registered vsync
active_o  out  1  registered active video
x_o  out  H_W  active pixel x; 0 when not active
y_o  out  V_W  active pixel y; 0 when not active
fetch_o  out  1  prefetch window flag
fetch_x_o  out  H_W  x of pixel being fetched; 0 outside window
fetch_y_o  out  V_W  y of pixel being fetched; 0 outside window
line_start_o  out  1  one-clk pulse at line start
frame_start_o  out  1  one-clk pulse at frame start
hc_o  out  H_W  raw horizontal counter
vc_o  out  V_W  raw vertical counter
frame_cnt_o  out  FRAME_W  completed-frame count, wraps modulo 2^FRAME_W

Behaviour:
- Derived values: H_BLANK=H_FP+H_SYNC+H_BP, H_TOTAL=H_BLANK+H_ACTIVE; V_BLANK and V_TOTAL are defined the same way. Elaboration error if H_TOTAL-1 does not fit in H_W, V_TOTAL-1 does not fit in V_W, or PREFETCH>H_BLANK.
- Line order: FP, sync, BP, then active. The frame follows the same order in lines.
- Reset (rst_i=1, async): hc_o=0, vc_o=0, frame_cnt_o=0. hsync_o=!HS_POL, vsync_o=!VS_POL. active_o, fetch_o and both pulses are 0. All coordinates are 0.
- en_i=0: on every clock, regardless of ce_i, counters, frame_cnt_o and all outputs return to their reset values. Counting resumes from hc=vc=0 on the first ce_i=1 after en_i rises.
- Counters (en_i=1, ce_i=1):
  - hc increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, vc increments and wraps from V_TOTAL-1 to 0.
  - On the vc wrap, frame_cnt_o increments.
  - ce_i=0 holds everything.
- Decode outputs are registered on ce_i=1 cycles from the pre-update hc/vc. They therefore lag hc_o/vc_o by one ce cycle and are mutually aligned.
  - hsync_o=HS_POL iff H_FP<=hc<H_FP+H_SYNC; vsync_o is decoded the same way with vc.
  - active_o=1 iff hc>=H_BLANK and vc>=V_BLANK. When active, x_o=hc-H_BLANK and y_o=vc-V_BLANK.
  - fetch_o=1 iff vc>=V_BLANK and H_BLANK-PREFETCH<=hc<H_TOTAL-PREFETCH. When set, fetch_x_o=hc-(H_BLANK-PREFETCH) and fetch_y_o=vc-V_BLANK.
  - With PREFETCH=0, fetch outputs equal the active outputs.
- line_start_o is high for exactly one clk, the clock after a ce update decoding hc=0. frame_start_o behaves the same for hc=0 and vc=0. Both are 0 on clocks with ce_i=0 and never stretch across ce gaps.
- All arithmetic is unsigned; coordinate subtractions occur only inside their windows, so there is no underflow.

Optional Feature:
Macro VGA_VBLANK_IRQ_EN adds ports irq_ack_i (in, 1), irq_o (out, 1) and irq_ovf_o (out, 1), all reset to 0.
- irq_o sets in the same clock as frame_start_o and stays set until a clock with irq_ack_i=1. Set and ack in the same clock: set wins.
- irq_ovf_o sets when frame_start occurs while irq_o=1. It is cleared by the same ack.
- en_i=0 clears both.
- Without the macro, these ports and their logic do not exist.

Test Plan:
- Defaults, ce_i=1, en_i=1 after reset: hsync_o low for 96 clks, first falling edge 17 clks after release; line period 800 clks; vsync_o low for 2 lines; frame period 420000 clks.
- Defaults: active_o first rises on the clk after hc=160, vc=45 with x_o=0, y_o=0. Last active pixel is x_o=639, y_o=479. Coordinates are 0 outside the active window.
- PREFETCH=1: fetch_o leads active_o by exactly 1 pixel with matching fetch_x_o/fetch_y_o. PREFETCH=0: fetch outputs identical to active outputs on every clk.
- ce_i toggling 1,0,1,0: line period 1600 clks; line_start_o high exactly 1 clk per line; outputs stable during ce_i=0.
- Small timing (H 8/1/2/1, V 4/1/1/1), en_i dropped mid-line: next clk has hc_o=0, frame_cnt_o=0, sync inactive; restart gives identical sequence. Assert rst_i mid-frame: outputs go to reset values immediately, without waiting for a clock.
- VGA_VBLANK_IRQ_EN: irq_o sets at frame start. Ack in the same clk as the next frame start: irq_o stays 1. Two frames with no ack: irq_ovf_o=1. One ack clears both.
